// File: rtl/t_ff_counter_pkg.sv
// Shared mode encoding and widths for the T flip-flop counter bank.
// Consumers may build with T_FF_COUNTER_SAT_EN to make counting saturate.
package t_ff_counter_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'd0,
    MODE_TOGGLE = 3'd1,
    MODE_UP     = 3'd2,
    MODE_DOWN   = 3'd3,
    MODE_LOAD   = 3'd4
  } mode_e;

endpackage

// File: rtl/t_ff_counter_cell.sv
// Single T flip-flop bit: q toggles when t is high, synchronous active-low reset.
module t_ff_cell
  import t_ff_counter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_t,
  input  logic i_rst_val,
  output logic o_q,
  output logic o_q_bar
);

  logic r_q;

  // toggle state register with reset to the per-bit reset value
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_q <= i_rst_val;
    end else begin
      r_q <= r_q ^ i_t;
    end
  end

  assign o_q     = r_q;
  assign o_q_bar = ~r_q;

endmodule

// File: rtl/t_ff_counter.sv
// WIDTH-bit counter/toggle bank of T cells with terminal count and sticky overflow.
// Define T_FF_COUNTER_SAT_EN to saturate UP/DOWN counting instead of wrapping.
module t_ff_counter
  import t_ff_counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_t_mask,
  input  logic [WIDTH-1:0]  i_load_val,
  output logic [WIDTH-1:0]  o_q,
  output logic [WIDTH-1:0]  o_q_bar,
  output logic              o_tc,
  output logic              o_ovf
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_up_t;
  logic [WIDTH-1:0] w_dn_t;
  logic [WIDTH-1:0] w_t_raw;
  logic [WIDTH-1:0] w_t;
  logic             w_tc;
  logic             r_ovf;

  // ripple AND chains: a bit toggles once all lower bits are at the carry/borrow value
  always_comb begin
    w_up_t    = {WIDTH{1'b0}};
    w_dn_t    = {WIDTH{1'b0}};
    w_up_t[0] = 1'b1;
    w_dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_t[i] = w_up_t[i-1] & w_q[i-1];
      w_dn_t[i] = w_dn_t[i-1] & ~w_q[i-1];
    end
  end

  // terminal count: next enabled count edge crosses the wrap point
  always_comb begin
    w_tc = 1'b0;
    if (i_rst && i_en) begin
      case (i_mode)
        MODE_UP:   w_tc = &w_q;
        MODE_DOWN: w_tc = ~|w_q;
        default:   w_tc = 1'b0;
      endcase
    end else begin
      w_tc = 1'b0;
    end
  end

  // per-bit toggle request selected by mode
  always_comb begin
    w_t_raw = {WIDTH{1'b0}};
    if (i_en) begin
      case (i_mode)
        MODE_TOGGLE: w_t_raw = i_t_mask;
        MODE_UP:     w_t_raw = w_up_t;
        MODE_DOWN:   w_t_raw = w_dn_t;
        MODE_LOAD:   w_t_raw = w_q ^ i_load_val;
        default:     w_t_raw = {WIDTH{1'b0}};
      endcase
    end else begin
      w_t_raw = {WIDTH{1'b0}};
    end
  end

`ifdef T_FF_COUNTER_SAT_EN
  assign w_t = w_tc ? {WIDTH{1'b0}} : w_t_raw;
`else
  assign w_t = w_t_raw;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_t       (w_t[g]),
      .i_rst_val (RST_VAL[g]),
      .o_q       (w_q[g]),
      .o_q_bar   (o_q_bar[g])
    );
  end

  // sticky overflow: clearing on reset or LOAD outranks a coincident set
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ovf <= 1'b0;
    end else if (i_en && (i_mode == MODE_LOAD)) begin
      r_ovf <= 1'b0;
    end else if (w_tc) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign o_q   = w_q;
  assign o_tc  = w_tc;
  assign o_ovf = r_ovf;

endmodule

// File: tb/tb_t_ff_counter.sv
// Directed and randomised self-checking bench for t_ff_counter at WIDTH=4.
// Expected values follow T_FF_COUNTER_SAT_EN when the bench is built with it.
module tb_t_ff_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [3:0] t_mask;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       tc;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_q;
  logic       m_ovf;
  logic       m_tc;

  t_ff_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_mode     (mode),
    .i_t_mask   (t_mask),
    .i_load_val (load_val),
    .o_q        (q),
    .o_q_bar    (q_bar),
    .o_tc       (tc),
    .o_ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic [3:0] tm, input logic [3:0] lv);
    rst = r; en = e; mode = m; t_mask = tm; load_val = lv;
    #1;
  endtask

  // Behavioural model: tc from current state/inputs, then next-state update.
  task automatic model_tc();
    m_tc = rst && en && (((mode == 3'd2) && (m_q == 4'hF)) || ((mode == 3'd3) && (m_q == 4'h0)));
  endtask

  task automatic model_edge();
    logic [3:0] nq;
    nq = m_q;
    if (en) begin
      case (mode)
        3'd1:    nq = m_q ^ t_mask;
        3'd2:    nq = m_q + 4'd1;
        3'd3:    nq = m_q - 4'd1;
        3'd4:    nq = load_val;
        default: nq = m_q;
      endcase
    end
`ifdef T_FF_COUNTER_SAT_EN
    if (m_tc) nq = m_q;
`endif
    if (!rst) begin
      m_q   = 4'h0;
      m_ovf = 1'b0;
    end else begin
      m_q = nq;
      if (en && mode == 3'd4) m_ovf = 1'b0;
      else if (m_tc)          m_ovf = 1'b1;
    end
  endtask

  initial begin
    // reset held for two edges with counting requested
    drive(1'b0, 1'b1, 3'd2, 4'h0, 4'h0);
    step(); step();
    check("rst_q",     q,             4'h0);
    check("rst_qbar",  q_bar,         4'hF);
    check("rst_ovf",   {3'b000, ovf}, 4'h0);
    check("rst_tc",    {3'b000, tc},  4'h0);
    drive(1'b1, 1'b1, 3'd2, 4'h0, 4'h0);
    step(); step(); step();
    check("up3_q",     q,             4'h3);
    check("up3_qbar",  q_bar,         4'hC);

    // wrap at all-ones
    drive(1'b1, 1'b1, 3'd4, 4'h0, 4'hE);
    step();
    check("loadE_q",   q,             4'hE);
    drive(1'b1, 1'b1, 3'd2, 4'h0, 4'h0);
    check("tc_at_E",   {3'b000, tc},  4'h0);
    step();
    check("up_F_q",    q,             4'hF);
    check("tc_at_F",   {3'b000, tc},  4'h1);
    step();
`ifdef T_FF_COUNTER_SAT_EN
    check("wrap_q",    q,             4'hF);
`else
    check("wrap_q",    q,             4'h0);
`endif
    check("wrap_ovf",  {3'b000, ovf}, 4'h1);
    drive(1'b1, 1'b1, 3'd4, 4'h0, 4'h5);
    step();
    check("load5_q",   q,             4'h5);
    check("load5_ovf", {3'b000, ovf}, 4'h0);

    // down through zero
    drive(1'b1, 1'b1, 3'd4, 4'h0, 4'h0);
    step();
    drive(1'b1, 1'b1, 3'd3, 4'h0, 4'h0);
    check("tc_dn0",    {3'b000, tc},  4'h1);
    step();
`ifdef T_FF_COUNTER_SAT_EN
    check("dn_q",      q,             4'h0);
`else
    check("dn_q",      q,             4'hF);
`endif
    check("dn_ovf",    {3'b000, ovf}, 4'h1);

    // toggle, disable, reserved mode
    drive(1'b1, 1'b1, 3'd4, 4'h0, 4'hA);
    step();
    drive(1'b1, 1'b1, 3'd1, 4'h3, 4'h0);
    step();
    check("tog_q",     q,             4'h9);
    check("tog_ovf",   {3'b000, ovf}, 4'h0);
    drive(1'b1, 1'b0, 3'd2, 4'hF, 4'h0);
    check("en0_tc",    {3'b000, tc},  4'h0);
    step(); step(); step();
    check("en0_q",     q,             4'h9);
    drive(1'b1, 1'b1, 3'd6, 4'hF, 4'h3);
    check("rsv_tc",    {3'b000, tc},  4'h0);
    step();
    check("rsv_q",     q,             4'h9);

    // reset in the middle of counting, with ovf previously set
    drive(1'b1, 1'b1, 3'd4, 4'h0, 4'hF);
    step();
    drive(1'b1, 1'b1, 3'd2, 4'h0, 4'h0);
    step();
`ifdef T_FF_COUNTER_SAT_EN
    drive(1'b1, 1'b1, 3'd1, 4'h8, 4'h0);
`else
    drive(1'b1, 1'b1, 3'd1, 4'h7, 4'h0);
`endif
    step();
    check("pre_q",     q,             4'h7);
    check("pre_ovf",   {3'b000, ovf}, 4'h1);
    drive(1'b0, 1'b1, 3'd2, 4'h0, 4'h0);
    check("rst_tc0",   {3'b000, tc},  4'h0);
    step();
    check("mid_q",     q,             4'h0);
    check("mid_ovf",   {3'b000, ovf}, 4'h0);
    drive(1'b0, 1'b1, 3'd4, 4'h0, 4'hC);
    step();
    check("rst_load",  q,             4'h0);

    // randomised run against the model
    m_q   = 4'h0;
    m_ovf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
            3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      model_tc();
      check("rnd_tc",   {3'b000, tc},  {3'b000, m_tc});
      model_edge();
      step();
      check("rnd_q",    q,             m_q);
      check("rnd_qbar", q_bar,         ~m_q);
      check("rnd_ovf",  {3'b000, ovf}, {3'b000, m_ovf});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
